dwb_bus_fabric: RTL and testbench

//  Registered Wishbone-classic data-bus fabric between the CPU data port and the five SoC targets: memory, PWM, ADC, protection, comm.

---
 rtl/dwb_fabric_pkg.sv | 50 +++++
 rtl/dwb_addr_decode.sv | 30 +++
 rtl/dwb_bus_fabric.sv | 216 +++++++++++++++++++++
 tb/tb_dwb_bus_fabric.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dwb_fabric_pkg.sv
// rtl/dwb_fabric_pkg.sv - shared constants, address map and FSM encoding for the data-bus fabric
package dwb_fabric_pkg;

    localparam int NUM_SLV = 5;

    localparam int SLV_MEM  = 0;
    localparam int SLV_PWM  = 1;
    localparam int SLV_ADC  = 2;
    localparam int SLV_PROT = 3;
    localparam int SLV_COMM = 4;

    localparam logic [31:0] MEM_BASE    = 32'h0000_0000;
    localparam logic [31:0] MEM_MASK    = 32'hE000_0000;
    localparam logic [31:0] PERIPH_MASK = 32'hFFFF_0000;
    localparam logic [31:0] PWM_BASE    = 32'h4000_0000;
    localparam logic [31:0] ADC_BASE    = 32'h4001_0000;
    localparam logic [31:0] PROT_BASE   = 32'h4002_0000;
    localparam logic [31:0] COMM_BASE   = 32'h4003_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } fab_state_e;

    // Base address of target idx; out-of-range indices get a base no masked address can equal.
    function automatic logic [31:0] slv_base(input int idx);
        case (idx)
            SLV_MEM:  slv_base = MEM_BASE;
            SLV_PWM:  slv_base = PWM_BASE;
            SLV_ADC:  slv_base = ADC_BASE;
            SLV_PROT: slv_base = PROT_BASE;
            SLV_COMM: slv_base = COMM_BASE;
            default:  slv_base = 32'hFFFF_FFFF;
        endcase
    endfunction

    // Significant address bits for target idx.
    function automatic logic [31:0] slv_mask(input int idx);
        case (idx)
            SLV_MEM:  slv_mask = MEM_MASK;
            SLV_PWM,
            SLV_ADC,
            SLV_PROT,
            SLV_COMM: slv_mask = PERIPH_MASK;
            default:  slv_mask = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/dwb_addr_decode.sv
// rtl/dwb_addr_decode.sv - combinational address decoder producing a one-hot target hit
module dwb_addr_decode
    import dwb_fabric_pkg::*;
#(
    parameter int N_SLV = NUM_SLV
) (
    input  logic [31:0]      adr_i,
    output logic [N_SLV-1:0] hit_o,
    output logic             unmapped_o
);

    logic [N_SLV-1:0] hit;
    logic             found;

    // Lowest-index matching window wins, so at most one hit bit is ever set.
    always_comb begin
        hit   = '0;
        found = 1'b0;
        for (int i = 0; i < N_SLV; i++) begin
            if (!found && ((adr_i & slv_mask(i)) == slv_base(i))) begin
                hit[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign hit_o      = hit;
    assign unmapped_o = ~found;

endmodule

// File: rtl/dwb_bus_fabric.sv
// rtl/dwb_bus_fabric.sv - registered Wishbone-classic data-bus fabric with timeout and error capture
module dwb_bus_fabric
    import dwb_fabric_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8,
    parameter int N_SLV          = NUM_SLV
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        m_adr_i,
    input  logic [31:0]        m_dat_i,
    output logic [31:0]        m_dat_o,
    input  logic               m_we_i,
    input  logic [3:0]         m_sel_i,
    input  logic               m_cyc_i,
    input  logic               m_stb_i,
    output logic               m_ack_o,
    output logic               m_err_o,
    output logic [31:0]        s_adr_o,
    output logic [31:0]        s_dat_o,
    output logic               s_we_o,
    output logic [3:0]         s_sel_o,
    output logic [N_SLV-1:0]   s_cyc_o,
    output logic [N_SLV-1:0]   s_stb_o,
    input  logic [32*N_SLV-1:0] s_dat_i,
    input  logic [N_SLV-1:0]   s_ack_i,
    input  logic [N_SLV-1:0]   s_err_i,
    input  logic               err_clr_i,
    output logic               err_valid_o,
    output logic [31:0]        err_addr_o,
    output logic               timeout_irq_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    fab_state_e       state_q, state_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      wdat_q, wdat_d;
    logic             we_q, we_d;
    logic [3:0]       sel_q, sel_d;
    logic [N_SLV-1:0] tgt_q, tgt_d;
    logic             stb_q, stb_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [31:0]      rdat_q, rdat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic             err_valid_q, err_valid_d;
    logic [31:0]      err_addr_q, err_addr_d;

    logic [N_SLV-1:0] dec_hit;
    logic             dec_unmapped;
    logic             req;
    logic             sel_ack;
    logic             sel_err;
    logic [31:0]      sel_rdata;
    logic             err_resp;

    dwb_addr_decode #(
        .N_SLV(N_SLV)
    ) u_decode (
        .adr_i     (m_adr_i),
        .hit_o     (dec_hit),
        .unmapped_o(dec_unmapped)
    );

    assign req     = m_cyc_i & m_stb_i;
    assign sel_ack = |(s_ack_i & tgt_q);
    assign sel_err = |(s_err_i & tgt_q);

    // Read-data mux driven by the latched one-hot target; unselected lanes contribute zero.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (tgt_q[i]) begin
                sel_rdata = sel_rdata | s_dat_i[32*i +: 32];
            end
        end
    end

    // Access FSM: request latch, target wait with watchdog, single-cycle response.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        we_d    = we_q;
        sel_d   = sel_q;
        tgt_d   = tgt_q;
        stb_d   = stb_q;
        rdat_d  = rdat_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        tmo_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    adr_d  = m_adr_i;
                    wdat_d = m_dat_i;
                    we_d   = m_we_i;
                    sel_d  = m_sel_i;
                    cnt_d  = '0;
                    if (dec_unmapped) begin
                        tgt_d   = '0;
                        stb_d   = 1'b0;
                        err_d   = 1'b1;
                        rdat_d  = '0;
                        state_d = ST_RESP;
                    end else begin
                        tgt_d   = dec_hit;
                        stb_d   = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!m_cyc_i) begin
                    // Master abandoned the cycle: withdraw quietly.
                    stb_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (sel_err) begin
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                    rdat_d  = '0;
                    state_d = ST_RESP;
                end else if (sel_ack) begin
                    stb_d   = 1'b0;
                    ack_d   = 1'b1;
                    rdat_d  = sel_rdata;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    rdat_d  = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                stb_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign err_resp = (state_q == ST_RESP) && err_q;

    // Sticky first-error capture; a clear in the same cycle as a new error keeps the new one.
    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        if (err_clr_i) begin
            err_valid_d = err_resp;
            err_addr_d  = err_resp ? adr_q : 32'h0;
        end else if (err_resp && !err_valid_q) begin
            err_valid_d = 1'b1;
            err_addr_d  = adr_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            wdat_q      <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            tgt_q       <= '0;
            stb_q       <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdat_q      <= '0;
            cnt_q       <= '0;
            tmo_q       <= 1'b0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            tgt_q       <= tgt_d;
            stb_q       <= stb_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdat_q      <= rdat_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign m_dat_o       = rdat_q;
    assign m_ack_o       = ack_q;
    assign m_err_o       = err_q;
    assign s_adr_o       = adr_q;
    assign s_dat_o       = wdat_q;
    assign s_we_o        = we_q;
    assign s_sel_o       = sel_q;
    assign s_cyc_o       = tgt_q & {N_SLV{stb_q}};
    assign s_stb_o       = tgt_q & {N_SLV{stb_q}};
    assign err_valid_o   = err_valid_q;
    assign err_addr_o    = err_addr_q;
    assign timeout_irq_o = tmo_q;

endmodule

// File: tb/tb_dwb_bus_fabric.sv
// tb/tb_dwb_bus_fabric.sv - randomized scoreboard bench for the data-bus fabric
module tb_dwb_bus_fabric;

    localparam int NS  = 5;
    localparam int TMO = 16;

    localparam int K_ACK   = 0;
    localparam int K_ERR   = 1;
    localparam int K_BOTH  = 2;
    localparam int K_TMO   = 3;
    localparam int K_ABORT = 4;

    typedef struct {
        logic        is_err;
        logic [31:0] rdata;
        logic        tmo;
        int          cyc;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [31:0]     m_adr_i, m_dat_i, m_dat_o;
    logic            m_we_i;
    logic [3:0]      m_sel_i;
    logic            m_cyc_i, m_stb_i, m_ack_o, m_err_o;
    logic [31:0]     s_adr_o, s_dat_o;
    logic            s_we_o;
    logic [3:0]      s_sel_o;
    logic [NS-1:0]   s_cyc_o, s_stb_o;
    logic [32*NS-1:0] s_dat_i;
    logic [NS-1:0]   s_ack_i, s_err_i;
    logic            err_clr_i, err_valid_o, timeout_irq_o;
    logic [31:0]     err_addr_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    bit          ev;
    logic [31:0] ea;

    dwb_bus_fabric #(
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (5),
        .N_SLV         (NS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m_adr_i      (m_adr_i),
        .m_dat_i      (m_dat_i),
        .m_dat_o      (m_dat_o),
        .m_we_i       (m_we_i),
        .m_sel_i      (m_sel_i),
        .m_cyc_i      (m_cyc_i),
        .m_stb_i      (m_stb_i),
        .m_ack_o      (m_ack_o),
        .m_err_o      (m_err_o),
        .s_adr_o      (s_adr_o),
        .s_dat_o      (s_dat_o),
        .s_we_o       (s_we_o),
        .s_sel_o      (s_sel_o),
        .s_cyc_o      (s_cyc_o),
        .s_stb_o      (s_stb_o),
        .s_dat_i      (s_dat_i),
        .s_ack_i      (s_ack_i),
        .s_err_i      (s_err_i),
        .err_clr_i    (err_clr_i),
        .err_valid_o  (err_valid_o),
        .err_addr_o   (err_addr_o),
        .timeout_irq_o(timeout_irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Address map from the published memory map, written as plain range tests.
    function automatic int ref_decode(input logic [31:0] a);
        int page;
        page = int'(a >> 16);
        if (a < 32'h2000_0000) return 0;
        if (page >= 'h4000 && page <= 'h4003) return page - 'h4000 + 1;
        return -1;
    endfunction

    function automatic logic [31:0] rand_addr(input int cat);
        logic [31:0] r;
        r = $urandom;
        case (cat)
            0:       return r & 32'h1FFF_FFFF;
            1, 2, 3, 4: return {16'h4000 + 16'(cat - 1), r[15:0]};
            5:       return 32'h2000_0000 | (r & 32'h1FFF_FFFF);
            6:       return {16'h4004 + 16'($urandom_range(0, 200)), r[15:0]};
            default: return 32'h8000_0000 | r;
        endcase
    endfunction

    // Response monitor: every ack/err must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_ack_o || m_err_o) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp actual ack=%0b err=%0b required none", m_ack_o, m_err_o);
                end else begin
                    mon_e = sb_q.pop_front();
                    check32("resp_err", {31'b0, m_err_o}, {31'b0, mon_e.is_err});
                    check32("resp_ack", {31'b0, m_ack_o}, {31'b0, ~mon_e.is_err});
                    check32("resp_data", m_dat_o, mon_e.rdata);
                    check32("resp_tmo_irq", {31'b0, timeout_irq_o}, {31'b0, mon_e.tmo});
                    check32("resp_cycle", cyc_cnt, mon_e.cyc);
                end
            end else if (timeout_irq_o) begin
                checks++;
                errors++;
                $display("FAIL stray_irq actual=1 required=0");
            end
        end
    end

    task automatic check_status();
        check32("err_valid", {31'b0, err_valid_o}, {31'b0, ev});
        check32("err_addr", err_addr_o, ea);
    endtask

    // One WAIT cycle at a negedge: strobes must be held; other targets may chatter.
    task automatic wait_cycle(input int t, input logic [NS-1:0] oh);
        int other;
        check32("wait_stb", {27'b0, s_stb_o}, {27'b0, oh});
        check32("wait_cyc", {27'b0, s_cyc_o}, {27'b0, oh});
        if ($urandom_range(0, 2) == 0) begin
            other = (t + 1 + $urandom_range(0, NS - 2)) % NS;
            s_ack_i[other] = 1'b1;
            s_err_i[other] = $urandom_range(0, 1) == 1;
        end
        @(posedge clk);
        @(negedge clk);
        s_ack_i = '0;
        s_err_i = '0;
    endtask

    // Full master access, entered and left at a negedge with the fabric idle.
    task automatic access(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                          input logic [3:0] sel, input int kind, input int dly,
                          input logic [31:0] rdat, input bit clr);
        int            t;
        int            n_wait;
        exp_t          e;
        logic [NS-1:0] oh;
        bit            err_now;
        t = ref_decode(adr);
        for (int i = 0; i < NS; i++) s_dat_i[32*i +: 32] = $urandom;
        m_adr_i = adr;
        m_dat_i = wdat;
        m_we_i  = we;
        m_sel_i = sel;
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        err_now = (t < 0) || kind == K_ERR || kind == K_BOTH || kind == K_TMO;
        if (t < 0) begin
            e.is_err = 1'b1; e.rdata = '0; e.tmo = 1'b0; e.cyc = cyc_cnt + 1;
            sb_q.push_back(e);
        end else if (kind != K_ABORT) begin
            e.is_err = (kind != K_ACK);
            e.rdata  = (kind == K_ACK) ? rdat : 32'h0;
            e.tmo    = (kind == K_TMO);
            e.cyc    = cyc_cnt + ((kind == K_TMO) ? 1 + TMO : 2 + dly);
            sb_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        check32("s_adr", s_adr_o, adr);
        check32("s_dat", s_dat_o, wdat);
        check32("s_we", {31'b0, s_we_o}, {31'b0, we});
        check32("s_sel", {28'b0, s_sel_o}, {28'b0, sel});
        if (t < 0) begin
            check32("unmapped_stb", {27'b0, s_stb_o}, 32'h0);
        end else begin
            oh    = '0;
            oh[t] = 1'b1;
            if (kind == K_ABORT) begin
                for (int i = 0; i < dly; i++) wait_cycle(t, oh);
                m_cyc_i = 1'b0;
                m_stb_i = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check32("abort_cyc", {27'b0, s_cyc_o}, 32'h0);
                check_status();
                return;
            end
            n_wait = (kind == K_TMO) ? TMO : dly;
            for (int i = 0; i < n_wait; i++) wait_cycle(t, oh);
            if (kind != K_TMO) begin
                check32("wait_stb", {27'b0, s_stb_o}, {27'b0, oh});
                s_dat_i[32*t +: 32] = rdat;
                s_ack_i[t] = (kind == K_ACK) || (kind == K_BOTH);
                s_err_i[t] = (kind == K_ERR) || (kind == K_BOTH);
                @(posedge clk);
                @(negedge clk);
                s_ack_i = '0;
                s_err_i = '0;
            end
        end
        check32("resp_cyc_low", {27'b0, s_cyc_o}, 32'h0);
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        if (clr) err_clr_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        err_clr_i = 1'b0;
        if (clr) begin
            ev = err_now;
            ea = err_now ? adr : 32'h0;
        end else if (err_now && !ev) begin
            ev = 1'b1;
            ea = adr;
        end
        check_status();
    endtask

    task automatic idle_clear();
        err_clr_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        err_clr_i = 1'b0;
        ev = 1'b0;
        ea = '0;
        check_status();
    endtask

    initial begin
        int cat, kind, dly;
        rst = 1'b1;
        m_adr_i = '0; m_dat_i = '0; m_we_i = 1'b0; m_sel_i = '0;
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        s_dat_i = '0; s_ack_i = '0; s_err_i = '0; err_clr_i = 1'b0;
        ev = 1'b0; ea = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rst_ack_err", {30'b0, m_ack_o, m_err_o}, 32'h0);
        check32("rst_cyc", {27'b0, s_cyc_o}, 32'h0);
        check32("rst_sadr", s_adr_o, 32'h0);
        check32("rst_mdat", m_dat_o, 32'h0);
        check32("rst_err_status", {31'b0, err_valid_o}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        access(32'h0000_0100, 1'b0, 32'h0, 4'hF, K_ACK, 3, 32'hDEAD_BEEF, 1'b0);
        check32("rdata_hold", m_dat_o, 32'hDEAD_BEEF);
        access(32'h4002_0008, 1'b1, 32'h0000_005A, 4'hF, K_ACK, 1, 32'h1234_5678, 1'b0);
        access(32'h8000_0000, 1'b0, 32'h0, 4'h3, K_ACK, 0, 32'h0, 1'b0);
        access(32'h9000_0000, 1'b1, 32'h55, 4'h1, K_ACK, 0, 32'h0, 1'b0);
        check32("first_err_addr", err_addr_o, 32'h8000_0000);
        access(32'h4000_0010, 1'b0, 32'h0, 4'hF, K_TMO, 0, 32'h0, 1'b0);
        access(32'h4001_0004, 1'b0, 32'h0, 4'hF, K_BOTH, 2, 32'hCAFE_F00D, 1'b0);
        access(32'h4003_0004, 1'b0, 32'h0, 4'hF, K_ACK, 4, 32'hA5A5_0F0F, 1'b0);
        access(32'h0000_2000, 1'b1, 32'h77, 4'hF, K_ABORT, 2, 32'h0, 1'b0);

        // Reset in the middle of a wait on the protection target.
        m_adr_i = 32'h4002_0000; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check32("midrst_stb", {27'b0, s_stb_o}, 32'h0);
        check32("midrst_ack_err", {30'b0, m_ack_o, m_err_o}, 32'h0);
        m_cyc_i = 1'b0; m_stb_i = 1'b0; rst = 1'b0;
        ev = 1'b0; ea = '0;
        check_status();
        @(negedge clk);

        access(32'h8000_0000, 1'b0, 32'h0, 4'hF, K_ACK, 0, 32'h0, 1'b0);
        access(32'hA000_0000, 1'b0, 32'h0, 4'hF, K_ACK, 0, 32'h0, 1'b1);
        check32("clr_new_addr", err_addr_o, 32'hA000_0000);
        idle_clear();

        for (int n = 0; n < 150; n++) begin
            cat  = $urandom_range(0, 7);
            kind = $urandom_range(0, 9);
            if (kind == 9) kind = K_ACK;
            else if (kind >= 5) kind = kind - 4;
            if (kind == K_TMO && $urandom_range(0, 2) != 0) kind = K_ACK;
            dly = $urandom_range(0, 5);
            access(rand_addr(cat), $urandom_range(0, 1) == 1, $urandom, 4'($urandom),
                   kind, dly, $urandom, $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) idle_clear();
        end

        repeat (3) @(negedge clk);
        check32("sb_drain", sb_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
